// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, op
// encoding, mstatus field positions and trap constants.
package csr_pkg;

   localparam int XLEN = 32;

   // Implemented CSR addresses
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

   // Zicsr operation encoding as delivered by decode
   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   // mstatus field positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [31:0] MSTATUS_RST_DEF = 32'h0000_1800;
   localparam logic [31:0] ECALL_CAUSE_DEF = 32'd11;

   // Builds an mstatus image: only MIE/MPIE are live, MPP is hardwired to M-mode.
   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MIE]                   = mie;
      v[MSTATUS_MPIE]                  = mpie;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr new-value generation. RS/RC with a zero operand
// must not write, so the write enable is produced here alongside the value.
module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_old,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_new,
   output logic            o_we
);

   // Compute read-modify-write result and whether it should be committed
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      o_new = i_old;
      o_we  = 1'b0;
      unique case (csr_op_e'(i_op))
         CSR_RW: begin
            o_new = i_wdata;
            o_we  = 1'b1;
         end
         CSR_RS: begin
            o_new = i_old | i_wdata;
            o_we  = |i_wdata;
         end
         CSR_RC: begin
            o_new = i_old & ~i_wdata;
            o_we  = |i_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file: Zicsr read-modify-write, ecall trap entry,
// mret return and a free-running 64-bit mcycle counter.
module csr_file
   import csr_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_DEF,
   parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            ecall,
   input  logic            mret,
   input  logic [XLEN-1:0] pc,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] regs_0,
   output logic [XLEN-1:0] regs_1,
   output logic [XLEN-1:0] regs_2,
   output logic [XLEN-1:0] regs_3
);

   logic [XLEN-1:0] r_mstatus;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [63:0]     r_mcycle;

   logic            w_hit;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic            w_alu_we;
   logic            w_csr_we;

   // Address decode and zero-latency read of the current value
   always_comb begin
      w_hit = 1'b1;
      w_old = '0;
      case (csr_addr)
         ADDR_MSTATUS: w_old = r_mstatus;
         ADDR_MTVEC:   w_old = r_mtvec;
         ADDR_MEPC:    w_old = r_mepc;
         ADDR_MCAUSE:  w_old = r_mcause;
         ADDR_MCYCLE:  w_old = r_mcycle[31:0];
         ADDR_MCYCLEH: w_old = r_mcycle[63:32];
         default:      w_hit = 1'b0;
      endcase
   end

   csr_alu #(.XLEN(XLEN)) u_alu (
      .i_op    (csr_op),
      .i_old   (w_old),
      .i_wdata (csr_wdata),
      .o_new   (w_new),
      .o_we    (w_alu_we)
   );

   // Trap entry and return take precedence; a CSR op in that cycle is dropped.
   assign w_csr_we    = w_alu_we && w_hit && !ecall && !mret;
   assign csr_rdata   = w_old;
   assign csr_illegal = (csr_op_e'(csr_op) != CSR_NONE) && !w_hit;
   assign redirect    = ecall | mret;
   assign redirect_pc = ecall ? r_mtvec : r_mepc;

   assign regs_0 = r_mstatus;
   assign regs_1 = r_mtvec;
   assign regs_2 = r_mepc;
   assign regs_3 = r_mcause;

   // Architectural CSR update: ecall > mret > CSR write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         r_mstatus <= MSTATUS_RST;
         r_mtvec   <= '0;
         r_mepc    <= '0;
         r_mcause  <= '0;
      end else if (ecall) begin
         r_mepc    <= {pc[XLEN-1:2], 2'b00};
         r_mcause  <= ECALL_CAUSE;
         r_mstatus <= mstatus_pack(1'b0, r_mstatus[MSTATUS_MIE]);
      end else if (mret) begin
         r_mstatus <= mstatus_pack(r_mstatus[MSTATUS_MPIE], 1'b1);
      end else if (w_csr_we) begin
         case (csr_addr)
            ADDR_MSTATUS: r_mstatus <= mstatus_pack(w_new[MSTATUS_MIE], w_new[MSTATUS_MPIE]);
            ADDR_MTVEC:   r_mtvec   <= {w_new[XLEN-1:2], 2'b00};
            ADDR_MEPC:    r_mepc    <= {w_new[XLEN-1:2], 2'b00};
            ADDR_MCAUSE:  r_mcause  <= w_new;
            default: ;
         endcase
      end
   end

   // mcycle: free-running, a write to either half replaces it and skips the increment
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mcycle <= '0;
      end else if (w_csr_we && csr_addr == ADDR_MCYCLE) begin
         r_mcycle <= {r_mcycle[63:32], w_new};
      end else if (w_csr_we && csr_addr == ADDR_MCYCLEH) begin
         r_mcycle <= {w_new, r_mcycle[31:0]};
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a table of single-cycle vectors with
// hand-computed results, plus sequences for mcycle and asynchronous reset.
module tb_csr_file;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   logic        clock;
   logic        reset;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        ecall;
   logic        mret;
   logic [31:0] pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] regs_0, regs_1, regs_2, regs_3;

   int n_chk = 0;
   int n_err = 0;

   csr_file dut (
      .clock       (clock),
      .reset       (reset),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .ecall       (ecall),
      .mret        (mret),
      .pc          (pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .regs_0      (regs_0),
      .regs_1      (regs_1),
      .regs_2      (regs_2),
      .regs_3      (regs_3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        ecall;
      logic        mret;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        illegal;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] r0, r1, r2, r3;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      csr_op    = OP_NONE;
      csr_wdata = '0;
      ecall     = 1'b0;
      mret      = 1'b0;
   endtask

   // Called just after a rising edge: drive, let the edge commit, clear the op.
   task automatic csr_cycle(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
      @(posedge clock);
      #1;
      idle_inputs();
   endtask

   task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
      csr_addr = addr;
      #1;
      check(name, csr_rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //                op       addr    wdata         ec mr pc            rdata         il rd rpc           r0            r1            r2            r3
      vecs[0]  = '{OP_RW,   12'h305, 32'h80000103, 0, 0, 32'h0,        32'h00000000, 0, 0, 32'h0,        32'h00001800, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[1]  = '{OP_RS,   12'h300, 32'h00000008, 0, 0, 32'h0,        32'h00001800, 0, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[2]  = '{OP_RC,   12'h300, 32'h00000008, 0, 0, 32'h0,        32'h00001808, 0, 0, 32'h0,        32'h00001800, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[3]  = '{OP_RS,   12'h305, 32'h00000000, 0, 0, 32'h0,        32'h80000100, 0, 0, 32'h0,        32'h00001800, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[4]  = '{OP_RC,   12'h305, 32'h80000000, 0, 0, 32'h0,        32'h80000100, 0, 0, 32'h0,        32'h00001800, 32'h00000100, 32'h00000000, 32'h00000000};
      vecs[5]  = '{OP_RW,   12'h305, 32'h80000100, 0, 0, 32'h0,        32'h00000100, 0, 0, 32'h0,        32'h00001800, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[6]  = '{OP_RW,   12'h300, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h00001800, 0, 0, 32'h0,        32'h00001888, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[7]  = '{OP_RW,   12'h300, 32'h00000000, 0, 0, 32'h0,        32'h00001888, 0, 0, 32'h0,        32'h00001800, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[8]  = '{OP_RS,   12'h300, 32'h00000008, 0, 0, 32'h0,        32'h00001800, 0, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h00000000, 32'h00000000};
      vecs[9]  = '{OP_RW,   12'h341, 32'h12345677, 0, 0, 32'h0,        32'h00000000, 0, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h12345674, 32'h00000000};
      vecs[10] = '{OP_RW,   12'h342, 32'hDEADBEEF, 0, 0, 32'h0,        32'h00000000, 0, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h12345674, 32'hDEADBEEF};
      vecs[11] = '{OP_RW,   12'h7C0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h00000000, 1, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h12345674, 32'hDEADBEEF};
      vecs[12] = '{OP_NONE, 12'h7C0, 32'h00000000, 0, 0, 32'h0,        32'h00000000, 0, 0, 32'h0,        32'h00001808, 32'h80000100, 32'h12345674, 32'hDEADBEEF};
      vecs[13] = '{OP_NONE, 12'h300, 32'h00000000, 1, 0, 32'h80000024, 32'h00001808, 0, 1, 32'h80000100, 32'h00001880, 32'h80000100, 32'h80000024, 32'h0000000B};
      vecs[14] = '{OP_NONE, 12'h341, 32'h00000000, 0, 1, 32'h0,        32'h80000024, 0, 1, 32'h80000024, 32'h00001888, 32'h80000100, 32'h80000024, 32'h0000000B};
      vecs[15] = '{OP_RW,   12'h341, 32'hAAAAAAAA, 1, 1, 32'h80000044, 32'h80000024, 0, 1, 32'h80000100, 32'h00001880, 32'h80000100, 32'h80000044, 32'h0000000B};
      vecs[16] = '{OP_RW,   12'h305, 32'h00000000, 0, 1, 32'h0,        32'h80000100, 0, 1, 32'h80000044, 32'h00001888, 32'h80000100, 32'h80000044, 32'h0000000B};
      vecs[17] = '{OP_RS,   12'h342, 32'h00000004, 1, 0, 32'h80000057, 32'h0000000B, 0, 1, 32'h80000100, 32'h00001880, 32'h80000100, 32'h80000054, 32'h0000000B};
      vecs[18] = '{OP_NONE, 12'h000, 32'h00000000, 0, 1, 32'h0,        32'h00000000, 0, 1, 32'h80000054, 32'h00001888, 32'h80000100, 32'h80000054, 32'h0000000B};

      // Reset state
      idle_inputs();
      csr_addr = 12'h000;
      pc       = '0;
      reset    = 1'b0;
      @(negedge clock);
      check("rst regs_0", regs_0, 32'h00001800);
      check("rst regs_1", regs_1, 32'h0);
      check("rst regs_2", regs_2, 32'h0);
      check("rst regs_3", regs_3, 32'h0);
      check("rst redirect", {31'b0, redirect}, 32'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Table-driven single-cycle vectors
      for (int i = 0; i < 19; i++) begin
         csr_op    = vecs[i].op;
         csr_addr  = vecs[i].addr;
         csr_wdata = vecs[i].wdata;
         ecall     = vecs[i].ecall;
         mret      = vecs[i].mret;
         pc        = vecs[i].pc;
         #2;
         check($sformatf("v%0d rdata", i), csr_rdata, vecs[i].rdata);
         check($sformatf("v%0d illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].illegal});
         check($sformatf("v%0d redirect", i), {31'b0, redirect}, {31'b0, vecs[i].redir});
         if (vecs[i].redir)
            check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
         @(posedge clock);
         #1;
         idle_inputs();
         check($sformatf("v%0d regs_0", i), regs_0, vecs[i].r0);
         check($sformatf("v%0d regs_1", i), regs_1, vecs[i].r1);
         check($sformatf("v%0d regs_2", i), regs_2, vecs[i].r2);
         check($sformatf("v%0d regs_3", i), regs_3, vecs[i].r3);
      end

      // mcycle counts edges since reset release
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      read_chk("mcycle after 3", 12'hB00, 32'd3);
      read_chk("mcycleh after 3", 12'hB80, 32'd0);

      // Write to the high half holds the low half for that cycle
      csr_cycle(OP_RW, 12'hB80, 32'h00000005);
      read_chk("mcycle held", 12'hB00, 32'd3);
      read_chk("mcycleh written", 12'hB80, 32'd5);

      // Low-half overflow carries into the high half
      csr_cycle(OP_RW, 12'hB00, 32'hFFFFFFFF);
      read_chk("mcycle written", 12'hB00, 32'hFFFFFFFF);
      read_chk("mcycleh kept", 12'hB80, 32'd5);
      @(posedge clock);
      #1;
      read_chk("mcycle carry lo", 12'hB00, 32'h0);
      read_chk("mcycleh carry hi", 12'hB80, 32'd6);

      // Full 64-bit wrap
      csr_cycle(OP_RW, 12'hB80, 32'hFFFFFFFF);
      csr_cycle(OP_RW, 12'hB00, 32'hFFFFFFFF);
      read_chk("mcycle max lo", 12'hB00, 32'hFFFFFFFF);
      read_chk("mcycle max hi", 12'hB80, 32'hFFFFFFFF);
      @(posedge clock);
      #1;
      read_chk("mcycle wrap lo", 12'hB00, 32'h0);
      read_chk("mcycle wrap hi", 12'hB80, 32'h0);

      // Asynchronous reset in the middle of a pending write
      csr_cycle(OP_RW, 12'h305, 32'h80000100);
      check("pre-reset mtvec", regs_1, 32'h80000100);
      csr_op    = OP_RW;
      csr_addr  = 12'h305;
      csr_wdata = 32'h11111100;
      #2;
      reset = 1'b0;
      #1;
      check("async rst mtvec", regs_1, 32'h0);
      check("async rst mstatus", regs_0, 32'h00001800);
      @(posedge clock);
      #1;
      check("held rst mtvec", regs_1, 32'h0);
      idle_inputs();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("post rst mtvec", regs_1, 32'h0);
      read_chk("post rst mcycle", 12'hB00, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
